// File: rtl/fetch_top.sv
// fetch_top: etcpu instruction-fetch stage (PC, predecode/prediction, IF/ID pipe register).
// Define ETCPU_BHT_EN to replace static backward-taken branch prediction with a 2-bit BHT.
module fetch_top #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BHT_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        intrlock_bubble,
    input  logic        ex_branch_flush,
    input  logic [31:0] ex_branch_target,
    input  logic        ex_branch_upd,
    input  logic [31:0] ex_branch_upd_pc,
    input  logic        ex_branch_upd_taken,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_branch_taken,
    output logic [31:0] if_branch_nt_pc
);

    localparam logic [31:0] BUBBLE    = 32'h0000_0013;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    function automatic logic [31:0] j_imm_f(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm_f(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    logic [31:0] pc_r;
    logic [31:0] pc_plus4_s;
    logic [31:0] pc_next_s;
    logic [6:0]  opcode_s;
    logic [31:0] j_imm_s;
    logic [31:0] b_imm_s;
    logic        branch_pred_s;
    logic        pred_taken_s;
    logic [31:0] pred_target_s;

    logic [31:0] if_inst_r;
    logic [31:0] if_pc_r;
    logic        if_branch_taken_r;
    logic [31:0] if_branch_nt_pc_r;
    logic [31:0] if_inst_next_s;
    logic [31:0] if_pc_next_s;
    logic        if_branch_taken_next_s;
    logic [31:0] if_branch_nt_pc_next_s;

    assign pc_plus4_s = pc_r + 32'd4;
    assign opcode_s   = imem_rdata[6:0];
    assign j_imm_s    = j_imm_f(imem_rdata);
    assign b_imm_s    = b_imm_f(imem_rdata);

`ifdef ETCPU_BHT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    function automatic logic [1:0] sat_update_f(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    logic [1:0]       bht_r [BHT_DEPTH];
    logic [IDX_W-1:0] rd_idx_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic             unused_bht_s;

    assign rd_idx_s      = pc_r[IDX_W+1:2];
    assign wr_idx_s      = ex_branch_upd_pc[IDX_W+1:2];
    // Counter >= 2'b10 is exactly its MSB; the lookup reads pre-update state.
    assign branch_pred_s = bht_r[rd_idx_s][1];
    assign unused_bht_s  = ^{ex_branch_upd_pc[31:IDX_W+2], ex_branch_upd_pc[1:0]};

    // BHT counters: weakly not-taken after reset, saturating update from execute
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bht_r <= '{default: 2'b01};
        end else if (ex_branch_upd) begin
            bht_r[wr_idx_s] <= sat_update_f(bht_r[wr_idx_s], ex_branch_upd_taken);
        end
    end
`else
    logic unused_bht_s;

    // Static BTFN: a negative branch offset means a loop back-edge.
    assign branch_pred_s = b_imm_s[31];
    assign unused_bht_s  = ^{ex_branch_upd, ex_branch_upd_pc, ex_branch_upd_taken};
`endif

    logic unused_low_s;
    assign unused_low_s = ^{ex_branch_target[1:0], pred_target_s[1:0]};

    // Predecode the fetched word into a taken prediction and its target
    always_comb begin
        pred_taken_s  = 1'b0;
        pred_target_s = pc_plus4_s;
        case (opcode_s)
            OP_JAL: begin
                pred_taken_s  = 1'b1;
                pred_target_s = pc_r + j_imm_s;
            end
            OP_BRANCH: begin
                pred_taken_s  = branch_pred_s;
                pred_target_s = pc_r + b_imm_s;
            end
            default: begin
                pred_taken_s  = 1'b0;
                pred_target_s = pc_plus4_s;
            end
        endcase
    end

    // Next-PC selection: redirect, then stall, then prediction, then sequential
    always_comb begin
        pc_next_s = pc_plus4_s;
        if (ex_branch_flush) begin
            pc_next_s = {ex_branch_target[31:2], 2'b00};
        end else if (intrlock_bubble) begin
            pc_next_s = pc_r;
        end else if (pred_taken_s) begin
            pc_next_s = {pred_target_s[31:2], 2'b00};
        end else begin
            pc_next_s = pc_plus4_s;
        end
    end

    // Program counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r <= {RESET_PC[31:2], 2'b00};
        end else begin
            pc_r <= pc_next_s;
        end
    end

    // IF/ID next state: flush inserts a bubble, stall holds, otherwise capture fetch
    always_comb begin
        if_inst_next_s         = if_inst_r;
        if_pc_next_s           = if_pc_r;
        if_branch_taken_next_s = if_branch_taken_r;
        if_branch_nt_pc_next_s = if_branch_nt_pc_r;
        if (ex_branch_flush) begin
            if_inst_next_s         = BUBBLE;
            if_pc_next_s           = 32'd0;
            if_branch_taken_next_s = 1'b0;
            if_branch_nt_pc_next_s = 32'd0;
        end else if (intrlock_bubble) begin
            if_inst_next_s         = if_inst_r;
            if_pc_next_s           = if_pc_r;
            if_branch_taken_next_s = if_branch_taken_r;
            if_branch_nt_pc_next_s = if_branch_nt_pc_r;
        end else begin
            if_inst_next_s         = imem_rdata;
            if_pc_next_s           = pc_r;
            if_branch_taken_next_s = pred_taken_s;
            if_branch_nt_pc_next_s = pc_plus4_s;
        end
    end

    // IF/ID pipe register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_inst_r         <= BUBBLE;
            if_pc_r           <= 32'd0;
            if_branch_taken_r <= 1'b0;
            if_branch_nt_pc_r <= 32'd0;
        end else begin
            if_inst_r         <= if_inst_next_s;
            if_pc_r           <= if_pc_next_s;
            if_branch_taken_r <= if_branch_taken_next_s;
            if_branch_nt_pc_r <= if_branch_nt_pc_next_s;
        end
    end

    assign imem_addr       = pc_r;
    assign if_inst         = if_inst_r;
    assign if_pc           = if_pc_r;
    assign if_branch_taken = if_branch_taken_r;
    assign if_branch_nt_pc = if_branch_nt_pc_r;

endmodule

// File: tb/tb_fetch_top.sv
// Scoreboard bench for fetch_top: a reference fetch model queues expected IF/ID contents
// each cycle; they are popped and compared after the clock edge.
module tb_fetch_top;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RST_PC   = 32'h0000_0100;
    localparam logic [31:0] JAL_P40  = 32'h0400_006F;
    localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;
    localparam logic [31:0] BEQ_P8   = 32'h0000_0463;
    localparam logic [31:0] BNE_P8   = 32'h0000_1463;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] nt_pc;
    } ifid_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        intrlock_bubble;
    logic        ex_branch_flush;
    logic [31:0] ex_branch_target;
    logic        ex_branch_upd;
    logic [31:0] ex_branch_upd_pc;
    logic        ex_branch_upd_taken;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_branch_taken;
    logic [31:0] if_branch_nt_pc;

    ifid_t       sb_q[$];
    ifid_t       m_if;
    logic [31:0] m_pc;
    logic [1:0]  m_bht [64];
    logic [31:0] mem_aa [logic [31:0]];
    int          n_checks;
    int          n_fail;

    fetch_top #(.RESET_PC(RST_PC), .BHT_DEPTH(64)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .imem_addr           (imem_addr),
        .imem_rdata          (imem_rdata),
        .intrlock_bubble     (intrlock_bubble),
        .ex_branch_flush     (ex_branch_flush),
        .ex_branch_target    (ex_branch_target),
        .ex_branch_upd       (ex_branch_upd),
        .ex_branch_upd_pc    (ex_branch_upd_pc),
        .ex_branch_upd_taken (ex_branch_upd_taken),
        .if_inst             (if_inst),
        .if_pc               (if_pc),
        .if_branch_taken     (if_branch_taken),
        .if_branch_nt_pc     (if_branch_nt_pc)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_aa.exists(a)) return mem_aa[a];
        return NOP;
    endfunction

    function automatic logic [31:0] ref_jimm(input logic [31:0] w);
        logic [31:0] r;
        r        = {32{w[31]}};
        r[19:12] = w[19:12];
        r[11]    = w[20];
        r[10:1]  = w[30:21];
        r[0]     = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] ref_bimm(input logic [31:0] w);
        logic [31:0] r;
        r       = {32{w[31]}};
        r[11]   = w[7];
        r[10:5] = w[30:25];
        r[4:1]  = w[11:8];
        r[0]    = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        m_pc = RST_PC;
        m_if = '{NOP, 32'd0, 1'b0, 32'd0};
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    endtask

    // One clock: drive inputs, predict expected state, compare after the edge.
    task automatic step(input logic bub, input logic fl, input logic [31:0] tgt,
                        input logic upd, input logic [31:0] upd_pc, input logic upd_tk);
        logic [31:0] w;
        logic [31:0] imm;
        logic [31:0] tgt_pc;
        logic        pred;
        ifid_t       exp_e;
        intrlock_bubble     = bub;
        ex_branch_flush     = fl;
        ex_branch_target    = tgt;
        ex_branch_upd       = upd;
        ex_branch_upd_pc    = upd_pc;
        ex_branch_upd_taken = upd_tk;
        imem_rdata          = mem_word(imem_addr);
        check_val("imem_addr", imem_addr, m_pc);
        w    = mem_word(m_pc);
        pred = 1'b0;
        imm  = 32'd4;
        if (w[6:0] == 7'b1101111) begin
            pred = 1'b1;
            imm  = ref_jimm(w);
        end else if (w[6:0] == 7'b1100011) begin
            imm = ref_bimm(w);
`ifdef ETCPU_BHT_EN
            pred = (m_bht[m_pc[7:2]] >= 2'd2);
`else
            pred = imm[31];
`endif
        end
        tgt_pc      = m_pc + imm;
        tgt_pc[1:0] = 2'b00;
        if (fl) begin
            m_if = '{NOP, 32'd0, 1'b0, 32'd0};
            m_pc = {tgt[31:2], 2'b00};
        end else if (!bub) begin
            m_if = '{w, m_pc, pred, m_pc + 32'd4};
            m_pc = pred ? tgt_pc : m_pc + 32'd4;
        end
        if (upd) begin
            if (upd_tk && m_bht[upd_pc[7:2]] != 2'b11) m_bht[upd_pc[7:2]] = m_bht[upd_pc[7:2]] + 2'd1;
            if (!upd_tk && m_bht[upd_pc[7:2]] != 2'b00) m_bht[upd_pc[7:2]] = m_bht[upd_pc[7:2]] - 2'd1;
        end
        sb_q.push_back(m_if);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            exp_e = sb_q.pop_front();
            check_val("if_inst", if_inst, exp_e.inst);
            check_val("if_pc", if_pc, exp_e.pc);
            check_val("if_taken", {31'd0, if_branch_taken}, {31'd0, exp_e.taken});
            check_val("if_nt_pc", if_branch_nt_pc, exp_e.nt_pc);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        step(1'b0, 1'b1, tgt, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_addr"}, imem_addr, RST_PC);
        check_val({tag, "_inst"}, if_inst, NOP);
        check_val({tag, "_pc"}, if_pc, 32'd0);
        check_val({tag, "_taken"}, {31'd0, if_branch_taken}, 32'd0);
        check_val({tag, "_ntpc"}, if_branch_nt_pc, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks            = 0;
        n_fail              = 0;
        rst_n               = 1'b0;
        intrlock_bubble     = 1'b0;
        ex_branch_flush     = 1'b0;
        ex_branch_target    = 32'd0;
        ex_branch_upd       = 1'b0;
        ex_branch_upd_pc    = 32'd0;
        ex_branch_upd_taken = 1'b0;
        imem_rdata          = NOP;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Sequential NOP stream from RESET_PC
        check_val("first_addr", imem_addr, 32'h100);
        idle();
        check_val("seq_104", imem_addr, 32'h104);
        idle();
        check_val("seq_108", imem_addr, 32'h108);

        // JAL +0x40 at 0x100, zero-bubble redirect
        mem_aa[32'h100] = JAL_P40;
        redirect(32'h100);
        check_val("flush_bubble", if_inst, NOP);
        idle();
        check_val("jal_addr", imem_addr, 32'h140);
        check_val("jal_taken", {31'd0, if_branch_taken}, 32'd1);
        check_val("jal_pc", if_pc, 32'h100);
        check_val("jal_ntpc", if_branch_nt_pc, 32'h104);

        // Backward and forward BEQ
        mem_aa[32'h200] = BEQ_M8;
        redirect(32'h200);
        idle();
`ifdef ETCPU_BHT_EN
        check_val("beq_back", imem_addr, 32'h204);
`else
        check_val("beq_back", imem_addr, 32'h1F8);
`endif
        mem_aa[32'h220] = BEQ_P8;
        redirect(32'h220);
        idle();
        check_val("beq_fwd", imem_addr, 32'h224);

        // Two-cycle stall at 0x300, then stall with flush
        redirect(32'h2F8);
        idle();
        idle();
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_val("stall1_addr", imem_addr, 32'h300);
        check_val("stall1_pc", if_pc, 32'h2FC);
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        check_val("stall2_addr", imem_addr, 32'h300);
        check_val("stall2_pc", if_pc, 32'h2FC);
        idle();
        check_val("resume_addr", imem_addr, 32'h304);
        step(1'b1, 1'b1, 32'h500, 1'b0, 32'd0, 1'b0);
        check_val("stflush_addr", imem_addr, 32'h500);
        check_val("stflush_inst", if_inst, NOP);

        // BNE +8 at 0x400: trained taken, then trained back to not-taken
        mem_aa[32'h400] = BNE_P8;
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h400, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h400, 1'b1);
        redirect(32'h400);
        idle();
`ifdef ETCPU_BHT_EN
        check_val("bht_taken", imem_addr, 32'h408);
`else
        check_val("bht_taken", imem_addr, 32'h404);
`endif
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h400, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 32'h400, 1'b0);
        redirect(32'h400);
        idle();
        check_val("bht_nt", imem_addr, 32'h404);

        // PC wrap at the top of the address space
        redirect(32'hFFFF_FFFC);
        idle();
        check_val("wrap", imem_addr, 32'h0);

        // Random mix of stalls, flushes (unaligned targets) and BHT updates
        for (int n = 0; n < 80; n++) begin
            step(($urandom % 4) == 0, ($urandom % 7) == 0, $urandom_range(32'h100, 32'h43F),
                 ($urandom % 3) == 0, {22'd0, 8'h00 + 8'($urandom_range(0, 255)), 2'b00},
                 1'($urandom));
        end

        // Reset mid-stream with flush and stall asserted
        rst_n               = 1'b0;
        ex_branch_flush     = 1'b1;
        intrlock_bubble     = 1'b1;
        ex_branch_target    = 32'h500;
        @(posedge clk);
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sb_q.delete();
        idle();
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_top.md
# fetch_top

Instruction-fetch stage of the etcpu pipeline, directly upstream of decode. Holds the program counter and drives the instruction-memory address. Predecodes the returned word to predict JAL and conditional branches. Registers instruction, PC and prediction into the IF/ID pipe register that decode consumes combinationally, and reacts to decode's interlock stall and execute's mispredict flush.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- BHT_DEPTH, 64, branch-history entries (power of 2, ≥4); used only with ETCPU_BHT_EN
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- imem_addr  out  32  current PC; imem_addr[1:0] always 2'b00
- imem_rdata  in  32  instruction at imem_addr, valid in the same cycle (asynchronous read)
- intrlock_bubble  in  1  decode interlock stall
- ex_branch_flush  in  1  execute mispredict/redirect
- ex_branch_target  in  32  correct next PC when ex_branch_flush=1
- ex_branch_upd  in  1  resolved conditional branch in execute (BHT update strobe)
- ex_branch_upd_pc  in  32  PC of the resolved branch
- ex_branch_upd_taken  in  1  actual outcome of the resolved branch
- if_inst  out  32  IF/ID instruction
- if_pc  out  32  IF/ID PC
- if_branch_taken  out  1  fetch predicted this instruction taken
- if_branch_nt_pc  out  32  fall-through PC of this instruction (if_pc+4)

## Operation
- Predecode imem_rdata: opcode = [6:0]; j_imm and b_imm use standard RV32I sign-extended encodings with bit0=0.
- Prediction:
  - JAL (7'b1101111): taken, target pc+j_imm.
  - BRANCH (7'b1100011): predicted per Configuration; target pc+b_imm.
  - JALR and all other opcodes: not taken.
- Next-PC priority:
  1. ex_branch_flush: pc ← {ex_branch_target[31:2],2'b00}
  2. intrlock_bubble: pc holds
  3. predicted taken: pc ← target
  4. otherwise: pc ← pc+4
- Adder arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0.
- IF/ID register, same priority:
  - flush: if_inst ← BUBBLE (32'h0000_0013), if_branch_taken ← 0, if_pc and if_branch_nt_pc ← 0.
  - stall: all four hold.
  - else: if_inst ← imem_rdata, if_pc ← pc, if_branch_taken ← prediction, if_branch_nt_pc ← pc+4.
- Flush together with stall: flush wins. The stalled decode instruction is squashed downstream anyway.
- Reset values:
  - pc = RESET_PC
  - if_inst = 32'h0000_0013
  - if_pc = 0, if_branch_nt_pc = 0, if_branch_taken = 0
  - BHT counters = 2'b01
- Reset takes precedence over flush and stall. Reset mid-stream discards all in-flight state.

## Timing
- Fetch-to-decode latency is 1 cycle. Word at imem_addr in cycle N appears on if_inst in N+1.
- Predicted-taken JAL/branch costs zero bubbles: the target is on imem_addr in N+1.
- Flush in cycle N:
  - imem_addr = ex_branch_target in N+1.
  - Decode sees BUBBLE in N+1 and the target instruction in N+2.
- Stall for k cycles: imem_addr and all if_* outputs are frozen for k cycles. Fetch resumes the cycle after intrlock_bubble drops.
- First instruction after reset release: imem_addr=RESET_PC in the first cycle with rst_n=1. That instruction reaches if_inst one cycle later.

## Configuration
- ETCPU_BHT_EN defined:
  - BHT_DEPTH×2-bit saturating counters, indexed by pc[log2(BHT_DEPTH)+1:2].
  - A BRANCH is predicted taken when its counter ≥ 2'b10.
  - When ex_branch_upd=1, the counter at ex_branch_upd_pc's index increments if taken (saturates at 3) and decrements if not taken (saturates at 0).
  - An update and a lookup of the same index in the same cycle: the lookup sees the old value; the write is visible next cycle.
- ETCPU_BHT_EN undefined:
  - Static backward-taken/forward-not-taken: a BRANCH is predicted taken iff b_imm[31]=1.
  - The ex_branch_upd* ports are ignored and no counter storage is built.

## Test plan
- Reset with RESET_PC=0x100, NOP memory → imem_addr 0x100, 0x104, 0x108 on successive cycles; if_inst=0x00000013 and if_pc=0 during reset.
- JAL offset +0x40 at 0x100 → next imem_addr=0x140; if_branch_taken=1, if_pc=0x100, if_branch_nt_pc=0x104, no bubble.
- Backward BEQ (offset −8) at 0x200, static build → imem_addr 0x1F8 next; forward BEQ (+8) → 0x204.
- intrlock_bubble high 2 cycles at pc=0x300 → imem_addr stays 0x300 and if_* frozen for 2 cycles; 0x304 follows. Same stall plus ex_branch_flush with target 0x500 → imem_addr=0x500 next, if_inst=0x00000013.
- BHT build: forward BNE at 0x400 updated taken twice → counter 01→10→11, next fetch of 0x400 predicts taken. Two not-taken updates → 11→10→01, predicts not-taken.
- PC 0xFFFFFFFC with non-branch → imem_addr wraps to 0x00000000.
